// File: rtl/word_byte_unpacker_pkg.sv
// Shared types, constants and keep helpers for the word-to-byte unpacker.
package word_byte_unpacker_pkg;

  localparam int unsigned ByteW     = 8;
  localparam int unsigned WordW     = 32;
  localparam int unsigned NB        = WordW / ByteW;
  localparam int unsigned HDR_BYTES = 44426;

  typedef enum logic [0:0] {
    StEmpty,
    StDrain
  } state_e;

  // Legal keep is a non-empty run of ones starting at bit 0 (2^k-1).
  function automatic logic keep_legal(logic [NB-1:0] keep);
    logic [NB-1:0] keep_p1;
    keep_p1 = keep + 1'b1;
    return (keep != '0) && ((keep & keep_p1) == '0);
  endfunction

  // Number of enabled bytes in a word.
  function automatic int unsigned keep_count(logic [NB-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(NB); i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/word_byte_unpacker_if.sv
// Word-in / byte-out stream bundle. The unpacker uses the slave view; the
// host/distributor environment uses the master view.
interface word_byte_unpacker_if #(
  parameter int unsigned WD = word_byte_unpacker_pkg::ByteW,
  parameter int unsigned WW = word_byte_unpacker_pkg::WordW
);
  localparam int unsigned NB = WW / WD;

  logic [WW-1:0] s_data;
  logic [NB-1:0] s_keep;
  logic          s_valid;
  logic          s_ready;
  logic [WD-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport slave (
    input  s_data, s_keep, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_keep, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

endinterface

// File: rtl/byte_counter_sat.sv
// Saturating event counter with a sticky, registered threshold flag and sync clear.
module byte_counter_sat #(
  parameter int unsigned CW     = 19,
  parameter int unsigned THRESH = 44426
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          flag
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  // Next count and flag; clear takes priority over an increment.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clr) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else begin
      if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      if (cnt_q >= CW'(THRESH)) flag_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign cnt  = cnt_q;
  assign flag = flag_q;

endmodule

// File: rtl/word_byte_unpacker.sv
// Serialises WW-bit words into WD-bit bytes, LSB byte first, and tracks bytes emitted.
module word_byte_unpacker #(
  parameter int unsigned WD        = word_byte_unpacker_pkg::ByteW,
  parameter int unsigned WW        = word_byte_unpacker_pkg::WordW,
  parameter int unsigned CW        = 19,
  parameter int unsigned HDR_BYTES = word_byte_unpacker_pkg::HDR_BYTES
) (
  input  logic                      clk,
  input  logic                      rstn,
  word_byte_unpacker_if.slave       bus,
  input  logic                      clr,
  output logic [CW-1:0]             byte_cnt,
  output logic                      hdr_done,
  output logic                      keep_err
);
  import word_byte_unpacker_pkg::*;

  localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;

  state_e          state_q, state_d;
  logic [WW-1:0]   hold_q, hold_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] last_q, last_d;
  logic            keep_err_q;
  logic            at_last;
  logic            s_xfer, m_xfer, word_ok;
  logic [WD-1:0]   byte_sel;

  assign s_xfer  = bus.s_valid && bus.s_ready;
  assign m_xfer  = bus.m_valid && bus.m_ready;
  assign word_ok = keep_legal(bus.s_keep);

  // State and datapath registers; reset discards any partially drained word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StEmpty;
      hold_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Next state: load legal words, step through bytes, reload on the last byte.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      StEmpty: begin
        if (s_xfer && word_ok) begin
          state_d = StDrain;
          hold_d  = bus.s_data;
          idx_d   = '0;
          last_d  = IdxW'(keep_count(bus.s_keep) - 1);
        end
      end
      StDrain: begin
        if (m_xfer) begin
          if (at_last) begin
            // Illegal words are swallowed here and leave the block empty.
            if (s_xfer && word_ok) begin
              hold_d = bus.s_data;
              idx_d  = '0;
              last_d = IdxW'(keep_count(bus.s_keep) - 1);
            end else begin
              state_d = StEmpty;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Outputs: byte mux, valid, and ready (open on the last-byte transfer for no bubble).
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (idx_q == IdxW'(i)) byte_sel = hold_q[i*WD +: WD];
    end
    at_last     = (state_q == StDrain) && (idx_q == last_q);
    bus.m_valid = (state_q == StDrain);
    bus.m_data  = bus.m_valid ? byte_sel : '0;
    bus.s_ready = rstn && ((state_q == StEmpty) || (at_last && bus.m_ready));
  end

  // Sticky illegal-keep flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      keep_err_q <= 1'b0;
    end else if (clr) begin
      keep_err_q <= 1'b0;
    end else if (s_xfer && !word_ok) begin
      keep_err_q <= 1'b1;
    end
  end

  assign keep_err = keep_err_q;

  byte_counter_sat #(
    .CW     (CW),
    .THRESH (HDR_BYTES)
  ) u_byte_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .inc  (m_xfer),
    .cnt  (byte_cnt),
    .flag (hdr_done)
  );

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Bench for word_byte_unpacker: scoreboard of expected bytes plus directed sequences.
module tb_word_byte_unpacker;

  localparam int unsigned HdrBytes = 44426;
  localparam int unsigned NWords   = 11107;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    int unsigned nbytes;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic [18:0] byte_cnt;
  logic        hdr_done;
  logic        keep_err;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  sb_q[$];

  word_byte_unpacker_if #(.WD(8), .WW(32)) u_bus ();

  word_byte_unpacker u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (u_bus),
    .clr      (clr),
    .byte_cnt (byte_cnt),
    .hdr_done (hdr_done),
    .keep_err (keep_err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count of bytes a keep value should produce, or -1 when the word is dropped.
  function automatic int model_count(logic [3:0] keep);
    int n;
    n = 0;
    while (n < 4 && keep[n]) n++;
    for (int i = n; i < 4; i++) begin
      if (keep[i]) return -1;
    end
    return (n == 0) ? -1 : n;
  endfunction

  // Scoreboard: pop on byte transfers, push on word transfers.
  always @(negedge clk) begin
    int n;
    if (rstn) begin
      if (u_bus.m_valid && u_bus.m_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got byte 0x%0h, want none", u_bus.m_data);
        end else begin
          check("sb_byte", {24'h0, u_bus.m_data}, {24'h0, sb_q.pop_front()});
        end
      end
      if (!u_bus.m_valid) check("m_data_idle", {24'h0, u_bus.m_data}, 32'h0);
      if (u_bus.s_valid && u_bus.s_ready) begin
        n = model_count(u_bus.s_keep);
        for (int i = 0; i < n; i++) sb_q.push_back(u_bus.s_data[8*i +: 8]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word; returns 1 time unit after the accepting edge.
  task automatic send_word(logic [31:0] d, logic [3:0] k);
    int t;
    t = 0;
    u_bus.s_data  = d;
    u_bus.s_keep  = k;
    u_bus.s_valid = 1'b1;
    @(negedge clk);
    while (!u_bus.s_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!u_bus.s_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got s_ready 0, want 1");
    end
    @(posedge clk);
    #1;
    u_bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (u_bus.m_valid && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (u_bus.m_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got m_valid 1, want 0");
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_s_ready"}, {31'h0, u_bus.s_ready}, 32'h0);
    check({tag, "_m_valid"}, {31'h0, u_bus.m_valid}, 32'h0);
    check({tag, "_m_data"}, {24'h0, u_bus.m_data}, 32'h0);
    check({tag, "_byte_cnt"}, {13'h0, byte_cnt}, 32'h0);
    check({tag, "_hdr_done"}, {31'h0, hdr_done}, 32'h0);
    check({tag, "_keep_err"}, {31'h0, keep_err}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs[8];
    logic [7:0] t1[4];
    logic [7:0] t3[4];
    logic [7:0] t6[4];
    bit         pat[4];
    int         mv_cnt, sr_cnt, done, cyc;

    u_bus.s_data  = '0;
    u_bus.s_keep  = '0;
    u_bus.s_valid = 1'b0;
    u_bus.m_ready = 1'b1;

    // Reset values, then first cycle after release.
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_s_ready", {31'h0, u_bus.s_ready}, 32'h1);
    check("rel_m_valid", {31'h0, u_bus.m_valid}, 32'h0);
    tick();

    // Single full word, cycle-exact.
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_word(32'h44332211, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("w1_m_valid", {31'h0, u_bus.m_valid}, 32'h1);
      check("w1_m_data", {24'h0, u_bus.m_data}, {24'h0, t1[i]});
      check("w1_s_ready", {31'h0, u_bus.s_ready}, (i == 3) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    check("w1_done_valid", {31'h0, u_bus.m_valid}, 32'h0);
    check("w1_byte_cnt", {13'h0, byte_cnt}, 32'd4);
    tick();

    // Back-to-back words with no bubble.
    u_bus.s_data  = 32'h04030201;
    u_bus.s_keep  = 4'hF;
    u_bus.s_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_ready", {31'h0, u_bus.s_ready}, 32'h1);
    @(posedge clk);
    #1;
    u_bus.s_data = 32'h08070605;
    mv_cnt = 0;
    sr_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      mv_cnt += int'(u_bus.m_valid);
      if (i < 8) sr_cnt += int'(u_bus.s_ready);
      if (u_bus.s_valid && u_bus.s_ready) begin
        @(posedge clk);
        #1;
        u_bus.s_valid = 1'b0;
      end
    end
    check("b2b_valid_cycles", mv_cnt, 8);
    check("b2b_ready_pulses", sr_cnt, 1);
    wait_idle();
    tick();

    // Backpressure pattern 1,0,0,1: byte holds across stalls.
    t3  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_word(32'hDDCCBBAA, 4'hF);
    done = 0;
    cyc  = 0;
    while (done < 4 && cyc < 40) begin
      u_bus.m_ready = pat[cyc % 4];
      @(negedge clk);
      check("stall_m_valid", {31'h0, u_bus.m_valid}, 32'h1);
      check("stall_m_data", {24'h0, u_bus.m_data}, {24'h0, t3[done]});
      check("stall_s_ready", {31'h0, u_bus.s_ready},
            (u_bus.m_ready && done == 3) ? 32'h1 : 32'h0);
      if (u_bus.m_ready) done++;
      cyc++;
      @(posedge clk);
      #1;
    end
    u_bus.m_ready = 1'b1;
    check("stall_bytes", done, 4);
    @(negedge clk);
    check("stall_idle", {31'h0, u_bus.m_valid}, 32'h0);
    tick();

    // Table: keep patterns, byte counts and keep_err, each after a clr.
    vecs = '{
      '{32'h00CCBBAA, 4'h7, 3, 1'b0},
      '{32'h12345678, 4'h5, 0, 1'b1},
      '{32'hA1B2C3D4, 4'h1, 1, 1'b0},
      '{32'h0000BEEF, 4'h3, 2, 1'b0},
      '{32'hCAFEF00D, 4'h0, 0, 1'b1},
      '{32'hDEADBEEF, 4'h8, 0, 1'b1},
      '{32'h13572468, 4'hE, 0, 1'b1},
      '{32'h87654321, 4'hF, 4, 1'b0}
    };
    for (int v = 0; v < 8; v++) begin
      pulse_clr();
      @(negedge clk);
      check("clr_keep_err", {31'h0, keep_err}, 32'h0);
      check("clr_byte_cnt", {13'h0, byte_cnt}, 32'h0);
      tick();
      send_word(vecs[v].data, vecs[v].keep);
      wait_idle();
      check("vec_byte_cnt", {13'h0, byte_cnt}, vecs[v].nbytes);
      check("vec_keep_err", {31'h0, keep_err}, {31'h0, vecs[v].err});
      tick();
    end

    // clr coincident with the first byte transfer: clr wins.
    send_word(32'h55667788, 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_idle();
    check("clr_vs_xfer", {13'h0, byte_cnt}, 32'd3);
    tick();

    // Reset in the middle of a word (idx 2), then a clean word.
    send_word(32'h44332211, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    sb_q.delete();
    #2;
    check_reset_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", {31'h0, u_bus.s_ready}, 32'h1);
    check("midrst_m_valid", {31'h0, u_bus.m_valid}, 32'h0);
    tick();
    t6 = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    send_word(32'h0D0C0B0A, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_m_data", {24'h0, u_bus.m_data}, {24'h0, t6[i]});
    end
    wait_idle();
    check("post_rst_byte_cnt", {13'h0, byte_cnt}, 32'd4);
    tick();

    // Header stream: hdr_done one cycle after byte_cnt hits HdrBytes.
    pulse_clr();
    fork
      begin
        for (int w = 0; w < int'(NWords); w++) send_word($urandom, 4'hF);
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (byte_cnt != 19'(HdrBytes) && t < 60000) begin
          t++;
          @(negedge clk);
        end
        check("hdr_reach", {13'h0, byte_cnt}, HdrBytes);
        check("hdr_not_yet", {31'h0, hdr_done}, 32'h0);
        @(negedge clk);
        check("hdr_rise", {31'h0, hdr_done}, 32'h1);
      end
    join
    wait_idle();
    check("stream_byte_cnt", {13'h0, byte_cnt}, NWords * 4);
    check("stream_hdr_done", {31'h0, hdr_done}, 32'h1);
    tick();
    pulse_clr();
    @(negedge clk);
    check("clr_hdr_done", {31'h0, hdr_done}, 32'h0);
    check("clr_after_stream", {13'h0, byte_cnt}, 32'h0);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
